// File: rtl/rtc_pkg.sv
// Shared field codes, range limits and the days-in-month table for the RTC calendar core.
package rtc_pkg;

    typedef enum logic [2:0] {
        FLD_SEC   = 3'd0,
        FLD_MIN   = 3'd1,
        FLD_HOUR  = 3'd2,
        FLD_DAY   = 3'd3,
        FLD_MONTH = 3'd4,
        FLD_YEAR  = 3'd5
    } field_e;

    localparam int SEC_MAX   = 59;
    localparam int MIN_MAX   = 59;
    localparam int HOUR_MAX  = 23;
    localparam int MONTH_MAX = 12;

    // Out-of-range month codes fall into the 31-day default so the result is always defined.
    function automatic logic [4:0] dim_lookup(input logic [3:0] month, input logic leap);
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: dim_lookup = 5'd30;
            4'd2:                    dim_lookup = leap ? 5'd29 : 5'd28;
            default:                 dim_lookup = 5'd31;
        endcase
    endfunction

endpackage

// File: rtl/rtc_days_in_month.sv
// Combinational Gregorian days-in-month and leap-year decode for one month/year pair.
module rtc_days_in_month
    import rtc_pkg::*;
#(
    parameter int YEAR_W = 12
) (
    input  logic [3:0]        month,
    input  logic [YEAR_W-1:0] year,
    output logic [4:0]        dim,
    output logic              is_leap
);

    logic [31:0] year_ext;

    assign year_ext = 32'(year);

    always_comb begin
        is_leap = ((year_ext % 32'd4) == 32'd0) &&
                  (((year_ext % 32'd100) != 32'd0) || ((year_ext % 32'd400) == 32'd0));
        dim     = dim_lookup(month, is_leap);
    end

endmodule

// File: rtl/rtc_calendar_core.sv
// Prescaled seconds-to-years calendar counter with validated field writes, pause, hh:mm alarm and rollover pulses.
module rtc_calendar_core
    import rtc_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int YEAR_W    = 12,
    parameter int BASE_YEAR = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pause,
    input  logic              set_valid,
    output logic              set_ready,
    input  logic [2:0]        set_field,
    input  logic [YEAR_W-1:0] set_value,
    input  logic              alarm_en,
    input  logic [4:0]        alarm_hour,
    input  logic [5:0]        alarm_min,
    output logic [5:0]        sec,
    output logic [5:0]        min,
    output logic [4:0]        hour,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic              sec_pulse,
    output logic              day_pulse,
    output logic              year_ovf,
    output logic              alarm,
    output logic              set_err
);

    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]     presc;
    logic [4:0]        cur_dim;
    logic [4:0]        cand_dim;
    logic              cur_leap;
    logic              cand_leap;
    logic              leap_unused;
    logic [3:0]        cand_month;
    logic [YEAR_W-1:0] cand_year;
    logic [4:0]        clamp_day;
    logic              write_req;
    logic              write_ok;
    logic              tick;

    logic              sec_wrap, min_wrap, hour_wrap, day_wrap, month_wrap;
    logic              c_min, c_hour, c_day, c_month, c_year;
    logic              year_wrap;
    logic              alarm_hit;
    logic [5:0]        nxt_sec, nxt_min;
    logic [4:0]        nxt_hour, nxt_day;
    logic [3:0]        nxt_month;
    logic [YEAR_W-1:0] nxt_year;

    // One decoder follows the live date, the other the date a month/year write would create.
    rtc_days_in_month #(.YEAR_W(YEAR_W)) u_dim_cur (
        .month   (month),
        .year    (year),
        .dim     (cur_dim),
        .is_leap (cur_leap)
    );

    rtc_days_in_month #(.YEAR_W(YEAR_W)) u_dim_cand (
        .month   (cand_month),
        .year    (cand_year),
        .dim     (cand_dim),
        .is_leap (cand_leap)
    );

    assign leap_unused = cur_leap ^ cand_leap;

    assign write_req = set_valid && set_ready;
    assign tick      = !write_req && !pause && (presc == PRESC_LAST);

    // Full carry chain so a year-end rollover resolves on a single edge.
    assign sec_wrap   = (sec == 6'(SEC_MAX));
    assign min_wrap   = (min == 6'(MIN_MAX));
    assign hour_wrap  = (hour == 5'(HOUR_MAX));
    assign day_wrap   = (day >= cur_dim);
    assign month_wrap = (month >= 4'(MONTH_MAX));

    assign c_min   = sec_wrap;
    assign c_hour  = c_min && min_wrap;
    assign c_day   = c_hour && hour_wrap;
    assign c_month = c_day && day_wrap;
    assign c_year  = c_month && month_wrap;

    assign nxt_sec   = sec_wrap ? 6'd0 : sec + 6'd1;
    assign nxt_min   = c_min ? (min_wrap ? 6'd0 : min + 6'd1) : min;
    assign nxt_hour  = c_hour ? (hour_wrap ? 5'd0 : hour + 5'd1) : hour;
    assign nxt_day   = c_day ? (day_wrap ? 5'd1 : day + 5'd1) : day;
    assign nxt_month = c_month ? (month_wrap ? 4'd1 : month + 4'd1) : month;
    assign nxt_year  = c_year ? year + YEAR_W'(1) : year;
    assign year_wrap = c_year && (year == '1);

    assign alarm_hit = alarm_en && (nxt_hour == alarm_hour) && (nxt_min == alarm_min) && (nxt_sec == 6'd0);

    always_comb begin
        write_ok   = 1'b0;
        cand_month = month;
        cand_year  = year;
        case (set_field)
            FLD_SEC:   write_ok = (set_value <= YEAR_W'(SEC_MAX));
            FLD_MIN:   write_ok = (set_value <= YEAR_W'(MIN_MAX));
            FLD_HOUR:  write_ok = (set_value <= YEAR_W'(HOUR_MAX));
            FLD_DAY:   write_ok = (set_value != '0) && (set_value <= YEAR_W'(cur_dim));
            FLD_MONTH: begin
                write_ok   = (set_value != '0) && (set_value <= YEAR_W'(MONTH_MAX));
                cand_month = set_value[3:0];
            end
            FLD_YEAR: begin
                write_ok  = 1'b1;
                cand_year = set_value;
            end
            default:   write_ok = 1'b0;
        endcase
    end

    assign clamp_day = (day > cand_dim) ? cand_dim : day;

    // A write (good or bad) restarts the second and takes priority over a coincident tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc     <= '0;
            sec       <= 6'd0;
            min       <= 6'd0;
            hour      <= 5'd0;
            day       <= 5'd1;
            month     <= 4'd1;
            year      <= YEAR_W'(BASE_YEAR);
            set_ready <= 1'b0;
            sec_pulse <= 1'b0;
            day_pulse <= 1'b0;
            year_ovf  <= 1'b0;
            alarm     <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            set_ready <= 1'b1;
            sec_pulse <= 1'b0;
            day_pulse <= 1'b0;
            year_ovf  <= 1'b0;
            alarm     <= 1'b0;
            set_err   <= 1'b0;
            if (write_req) begin
                presc <= '0;
                if (write_ok) begin
                    case (set_field)
                        FLD_SEC:   sec  <= set_value[5:0];
                        FLD_MIN:   min  <= set_value[5:0];
                        FLD_HOUR:  hour <= set_value[4:0];
                        FLD_DAY:   day  <= set_value[4:0];
                        FLD_MONTH: begin
                            month <= set_value[3:0];
                            day   <= clamp_day;
                        end
                        FLD_YEAR: begin
                            year <= set_value;
                            day  <= clamp_day;
                        end
                        default: ;
                    endcase
                end else begin
                    set_err <= 1'b1;
                end
            end else if (tick) begin
                presc     <= '0;
                sec       <= nxt_sec;
                min       <= nxt_min;
                hour      <= nxt_hour;
                day       <= nxt_day;
                month     <= nxt_month;
                year      <= nxt_year;
                sec_pulse <= 1'b1;
                day_pulse <= c_day;
                year_ovf  <= year_wrap;
                alarm     <= alarm_hit;
            end else if (!pause) begin
                presc <= presc + PW'(1);
            end
        end
    end

endmodule

// File: doc/rtc_calendar_core.md
Name: rtc_calendar_core

Overview:
- Parametrised timekeeping core for the clock/calendar display path. Counts sec/min/hour/day/month/year from a system clock through an internal prescaler, with full Gregorian leap-year handling.
- Adds a validated field-write handshake, pause, an hh:mm alarm, and rollover pulses.
- Feeds the existing display mux.

Parameters:
- TICK_DIV, 50000000, clk cycles per second; must be >= 2.
- YEAR_W, 12, year counter width.
- BASE_YEAR, 2000, year value loaded at reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- pause  in  1  freeze prescaler and counters while high
- set_valid  in  1  field write request
- set_ready  out  1  write accepted this cycle; constant 1 except during reset
- set_field  in  3  0=sec 1=min 2=hour 3=day 4=month 5=year; 6,7 reserved
- set_value  in  YEAR_W  write data, zero-extended per field
- alarm_en  in  1  alarm enable
- alarm_hour  in  5  alarm hour 0..23
- alarm_min  in  6  alarm minute 0..59
- sec  out  6  0..59
- min  out  6  0..59
- hour  out  5  0..23
- day  out  5  1..28/29/30/31
- month  out  4  1..12
- year  out  YEAR_W  current year
- sec_pulse  out  1  one cycle, coincident with each new second value
- day_pulse  out  1  one cycle on midnight rollover
- year_ovf  out  1  one cycle when year wraps from 2^YEAR_W-1 to 0
- alarm  out  1  one cycle at alarm match
- set_err  out  1  one cycle when a write is rejected

Behaviour:
- All state is registered on the clk rising edge. No combinational path from inputs to time outputs.
- Reset (rst_n=0 at an edge): sec=min=hour=0, day=month=1, year=BASE_YEAR, prescaler=0. All pulse outputs are 0 and set_ready is 0. Reset mid-write discards the write.
- Prescaler: counts 0..TICK_DIV-1 when pause=0. A tick is the cycle in which prescaler==TICK_DIV-1 and pause=0; the prescaler wraps to 0 on that cycle.
- pause=1: prescaler and counters hold. Resuming continues from the held prescaler value, so no tick is lost or duplicated.
- Tick update, applied on the same edge; sec_pulse=1 with the new value:
  - sec+1. At 59 it wraps to 0 and carries to min.
  - min wraps at 59 and carries to hour.
  - hour wraps at 23 and carries to day; day_pulse=1 on that carry.
  - day wraps to 1 after dim(month,year) and carries to month.
  - month wraps 12->1 and carries to year.
  - year+1 modulo 2^YEAR_W; year_ovf=1 on the wrap to 0.
  - All carries resolve within one cycle, e.g. 31/12 23:59:59 -> 01/01 00:00:00 of year+1 on a single edge.
- dim: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11. February is 29 if leap, else 28. Leap means year%4==0 and (year%100!=0 or year%400==0).
- Write: accepted when set_valid and set_ready are both high. The value is checked against its field range:
  - sec 0..59, min 0..59, hour 0..23, month 1..12, day 1..dim(current month, current year); year accepts any value.
  - Reserved set_field values are rejected.
  - On rejection, no state changes and set_err=1 on the next cycle.
- Write side effects:
  - Any accepted or rejected write clears the prescaler to 0 and suppresses a tick in the same cycle; the write wins.
  - Writing sec also restarts the second.
  - After an accepted month or year write, if day > new dim, day is clamped to the new dim on the same edge.
  - Writes are accepted while pause=1.
- Alarm: fires when alarm_en=1 and a tick produces hour==alarm_hour, min==alarm_min, sec==0; alarm=1 coincident with sec_pulse. Writes never fire the alarm. Out-of-range alarm inputs never match.
- Latency: write to outputs is 1 cycle. Tick to outputs is 0 cycles beyond the tick edge.

Decomposition:
- Package rtc_pkg holds:
  - field codes FLD_SEC..FLD_YEAR
  - SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, MONTH_MAX=12
  - the dim lookup function
- Sub-module rtc_days_in_month: a combinational block (month, year -> dim, is_leap). It is instantiated twice, once for the current date and once for the candidate month/year during a write, so the clamp is computed in the same cycle.

Test Plan:
- TICK_DIV=4, reset -> 00:00:00 01/01/2000; after 4 cycles sec=1 and sec_pulse=1 for exactly one cycle; 60 ticks -> min=1, sec=0.
- Set 2024/02/28 23:59:59, one tick -> 29/02 00:00:00 with day_pulse=1. Repeat with year=2100 -> 01/03. Repeat with year=2000 -> 29/02.
- Set 31/12/4095 23:59:59, YEAR_W=12, one tick -> 01/01/0000 00:00:00, with year_ovf, day_pulse and sec_pulse all 1 in the same cycle.
- Day=31, month=1, then write month=4 -> day=30. Write day=31 in month 4 -> set_err=1 and day stays 30. Write set_field=6 -> set_err=1.
- Hold pause=1 for 20 cycles at prescaler=2 -> no change; release -> tick after 1 more cycle. Assert set_valid in a tick cycle -> write applied, tick suppressed, prescaler=0.
- alarm_en=1, alarm 07:30, time 07:29:59, one tick -> alarm=1 for one cycle. Write time to 07:30:00 -> alarm stays 0.
